disp_scan_arbiter: RTL

Scan sequencer and two-port arbiter for the 4-digit seven-segment display driver. Generates the 2-bit digit-scan select and shares the display between two requesters, e.g. the CPU debug path (port 0) and the game score/status path (port 1). Each requester hands over a 32-bit display word and a 2-bit mode over a valid/ack handshake. Accepted words are staged and committed to the driver only at a frame boundary, so a single scan frame never mixes two words.

---
 rtl/disp_scan_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/disp_scan_arbiter.sv
// -----------------------------------------------------------------------------
// disp_scan_arbiter
//   Digit-scan sequencer plus two-port arbiter for a 4-digit seven-segment
//   display driver. Each port offers a 32-bit word and a 2-bit mode over a
//   valid/ack handshake. An accepted word is staged and only becomes live on a
//   frame boundary, so one scan frame never shows a mix of two words. A newly
//   granted owner keeps the display for at least HOLD_CYC cycles unless it
//   releases it.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   req_valid[1:0]  per-port request valid
//   req_num0/1    32-bit display word from port 0 / port 1
//   req_mode0/1   mode from port 0 / 1 (bit0: 1 = hex, bit1: 1 = high half)
//   req_rel[1:0]  per-port release strobe
//   req_ack[1:0]  combinational accept (transfer when valid && ack)
//   scanning_clk  digit-slot select, 0..3
//   disp_num      live word for the display driver
//   switch        live mode for the display driver
//   owner         current owner port
//   busy          display is owned (state not IDLE)
//   stage_dirty   a staged word is waiting for the next frame boundary
// -----------------------------------------------------------------------------
module disp_scan_arbiter #(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned HOLD_CYC = 25000000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    input  logic [31:0]      req_num0,
    input  logic [31:0]      req_num1,
    input  logic [1:0]       req_mode0,
    input  logic [1:0]       req_mode1,
    input  logic [1:0]       req_rel,
    output logic [1:0]       req_ack,
    output logic [1:0]       scanning_clk,
    output logic [31:0]      disp_num,
    output logic [1:0]       switch,
    output logic             owner,
    output logic             busy,
    output logic             stage_dirty
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW0 = 2'd1,
        ST_SHOW1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  div_cnt_r;
    logic [CNT_W-1:0]  hold_cnt_r, hold_nxt_s;
    logic [1:0]        scan_r;
    logic              owner_r, owner_nxt_s;
    logic              busy_r;
    logic [31:0]       stage_num_r;
    logic [1:0]        stage_mode_r;
    logic              stage_dirty_r;
    logic [31:0]       disp_num_r;
    logic [1:0]        switch_r;

    logic              slot_end_s;
    logic              frame_end_s;
    logic              idle_s;
    logic              hold_zero_s;
    logic [1:0]        elig_s;
    logic [1:0]        cand_s;
    logic [1:0]        grant_s;
    logic              xfer_s;
    logic              xfer_port_s;

    assign slot_end_s  = (div_cnt_r == SLOT_LAST);
    assign frame_end_s = slot_end_s && (scan_r == 2'd3);
    assign idle_s      = (state_r == ST_IDLE);
    assign hold_zero_s = (hold_cnt_r == CNT_ZERO);

    // A port may take the display when it is free, when it already owns it,
    // or once the current owner's minimum hold has run out.
    assign elig_s[0] = idle_s || (owner_r == 1'b0) || hold_zero_s;
    assign elig_s[1] = idle_s || (owner_r == 1'b1) || hold_zero_s;
    assign cand_s    = req_valid & elig_s;

    // Grant selection: at most one port; on a tie port 0 wins from IDLE,
    // otherwise the non-owner wins so a busy owner cannot starve the other.
    always_comb begin
        grant_s = 2'b00;
        if (rst) begin
            grant_s = 2'b00;
        end else begin
            case (cand_s)
                2'b01:   grant_s = 2'b01;
                2'b10:   grant_s = 2'b10;
                2'b11: begin
                    if (idle_s) begin
                        grant_s = 2'b01;
                    end else if (owner_r == 1'b0) begin
                        grant_s = 2'b10;
                    end else begin
                        grant_s = 2'b01;
                    end
                end
                default: grant_s = 2'b00;
            endcase
        end
    end

    assign xfer_s      = |grant_s;
    assign xfer_port_s = grant_s[1];

    // Next-state logic: a transfer from a new owner restarts the hold; an
    // owner refresh does not, so repeated updates never extend the hold.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        hold_nxt_s  = hold_cnt_r;
        if (!idle_s && !hold_zero_s) begin
            hold_nxt_s = hold_cnt_r - CNT_W'(1);
        end else begin
            hold_nxt_s = hold_cnt_r;
        end
        if (xfer_s) begin
            if (idle_s || (xfer_port_s != owner_r)) begin
                state_nxt_s = xfer_port_s ? ST_SHOW1 : ST_SHOW0;
                owner_nxt_s = xfer_port_s;
                hold_nxt_s  = HOLD_LOAD;
            end else begin
                state_nxt_s = state_r;
                owner_nxt_s = owner_r;
            end
        end else if (!idle_s && req_rel[owner_r]) begin
            state_nxt_s = ST_IDLE;
            hold_nxt_s  = CNT_ZERO;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Arbiter state, hold counter and the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            owner_r    <= 1'b0;
            hold_cnt_r <= CNT_ZERO;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            owner_r    <= owner_nxt_s;
            hold_cnt_r <= hold_nxt_s;
            busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    // Slot divider and digit-scan select.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r <= CNT_ZERO;
            scan_r    <= 2'd0;
        end else if (slot_end_s) begin
            div_cnt_r <= CNT_ZERO;
            scan_r    <= scan_r + 2'd1;
        end else begin
            div_cnt_r <= div_cnt_r + CNT_W'(1);
        end
    end

    // Staging and frame-boundary commit. On a transfer that coincides with
    // frame_end the old staged word goes live and the new one stays dirty.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_num_r   <= 32'd0;
            stage_mode_r  <= 2'b01;
            stage_dirty_r <= 1'b0;
            disp_num_r    <= 32'd0;
            switch_r      <= 2'b01;
        end else begin
            if (frame_end_s && stage_dirty_r) begin
                disp_num_r <= stage_num_r;
                switch_r   <= stage_mode_r;
            end
            if (xfer_s) begin
                stage_num_r   <= xfer_port_s ? req_num1 : req_num0;
                stage_mode_r  <= xfer_port_s ? req_mode1 : req_mode0;
                stage_dirty_r <= 1'b1;
            end else if (frame_end_s) begin
                stage_dirty_r <= 1'b0;
            end
        end
    end

    assign req_ack      = grant_s;
    assign scanning_clk = scan_r;
    assign disp_num     = disp_num_r;
    assign switch       = switch_r;
    assign owner        = owner_r;
    assign busy         = busy_r;
    assign stage_dirty  = stage_dirty_r;

endmodule
